// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Two-requester (I-cache = 0, D-cache = 1) round-robin arbiter
//               in front of a single higher-level memory port. A 1-cycle
//               arbitration state (IDLE) precedes every grant; the owner's
//               request is then passed straight through until it completes
//               or is abandoned.
//               Optional feature macro: MEM_ARB_LOCK_EN -- lets the current
//               owner keep the port for up to MAX_LOCK back-to-back
//               transactions so line fills / writebacks stay contiguous.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            reset,

    // Requester 0 (I-cache, loads only)
    input  logic            r0_valid,
    input  logic            r0_op,
    input  logic [XLEN-1:0] r0_address,
    input  logic [1:0]      r0_size,
    input  logic [XLEN-1:0] r0_store_word,
    output logic            r0_fulfilled,
    output logic [XLEN-1:0] r0_loaded_word,

    // Requester 1 (D-cache)
    input  logic            r1_valid,
    input  logic            r1_op,
    input  logic [XLEN-1:0] r1_address,
    input  logic [1:0]      r1_size,
    input  logic [XLEN-1:0] r1_store_word,
    output logic            r1_fulfilled,
    output logic [XLEN-1:0] r1_loaded_word,

    // Higher-level memory
    output logic            m_valid,
    output logic            m_op,
    output logic [XLEN-1:0] m_address,
    output logic [1:0]      m_size,
    output logic [XLEN-1:0] m_store_word,
    input  logic            m_fulfilled,
    input  logic [XLEN-1:0] m_loaded_word
);

    // Size encoding (memory_operation_size_e): 0 BYTE, 1 HALF, 2 WORD.

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("memory_arbiter: XLEN must be 32");
        end
        if ((MAX_LOCK < 1) || (MAX_LOCK > 255)) begin : g_bad_max_lock
            $error("memory_arbiter: MAX_LOCK must be in 1..255");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0] r_state;
    logic       r_owner;
    logic       r_last_owner;

    logic            w_busy;
    logic            w_any_valid;
    logic            w_winner;
    logic            w_sel_valid;
    logic            w_sel_op;
    logic [XLEN-1:0] w_sel_address;
    logic [1:0]      w_sel_size;
    logic [XLEN-1:0] w_sel_store_word;
    logic            w_m_valid;
    logic            w_retain;
    logic            w_to_idle;

    assign w_busy      = (r_state == c_st_busy);
    assign w_any_valid = r0_valid | r1_valid;

    // A lone requester wins; on a tie the one that did not finish last wins.
    assign w_winner = (r0_valid & r1_valid) ? ~r_last_owner : r1_valid;

    // Owner-side request multiplexer
    assign w_sel_valid      = r_owner ? r1_valid      : r0_valid;
    assign w_sel_op         = r_owner ? r1_op         : r0_op;
    assign w_sel_address    = r_owner ? r1_address    : r0_address;
    assign w_sel_size       = r_owner ? r1_size       : r0_size;
    assign w_sel_store_word = r_owner ? r1_store_word : r0_store_word;

    // Memory request is only live while BUSY; all fields read zero otherwise.
    assign w_m_valid    = w_busy & w_sel_valid;
    assign m_valid      = w_m_valid;
    assign m_op         = w_m_valid & w_sel_op;
    assign m_address    = w_m_valid ? w_sel_address    : {XLEN{1'b0}};
    assign m_size       = w_m_valid ? w_sel_size       : 2'b00;
    assign m_store_word = w_m_valid ? w_sel_store_word : {XLEN{1'b0}};

    // Completion goes to the owner only, and never while arbitrating.
    assign r0_fulfilled = w_busy & ~r_owner & m_fulfilled;
    assign r1_fulfilled = w_busy &  r_owner & m_fulfilled;

    // Load data is broadcast; only the owner sees a fulfilled strobe.
    assign r0_loaded_word = m_loaded_word;
    assign r1_loaded_word = m_loaded_word;

`ifdef MEM_ARB_LOCK_EN
    // ------------------------------------------------------------------------
    // Ownership lock: count transactions retained by the current owner
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_lock_limit = 8'(MAX_LOCK - 1);

    logic [7:0] r_lock_count;

    // Keep the port after a completion while the hold budget lasts; whether
    // the owner actually continues is decided by its valid next cycle.
    assign w_retain = (r_lock_count < c_lock_limit);

    // Lock counter: bump per retained completion, clear when leaving BUSY
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_count <= 8'd0;
        end else if (w_busy && m_fulfilled && w_retain) begin
            r_lock_count <= r_lock_count + 8'd1;
        end else if (w_to_idle) begin
            r_lock_count <= 8'd0;
        end
    end
`else
    assign w_retain = 1'b0;
`endif

    // Leave BUSY on a non-retained completion, or when the owner withdraws.
    assign w_to_idle = w_busy &
                       ((m_fulfilled & ~w_retain) | (~m_fulfilled & ~w_sel_valid));

    // Arbitration FSM with owner / last-owner tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any_valid) begin
                        r_owner <= w_winner;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (m_fulfilled) begin
                        r_last_owner <= r_owner;
                    end
                    if (w_to_idle) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter. Directed scenarios
//               plus randomized transaction streams checked against a
//               transaction-level grant-order model. Build with
//               MEM_ARB_LOCK_EN defined to exercise the ownership lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int c_max_lock = 8;

    typedef struct packed {
        logic        op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        r0_valid, r0_op, r0_fulfilled;
    logic [31:0] r0_address, r0_store_word, r0_loaded_word;
    logic [1:0]  r0_size;
    logic        r1_valid, r1_op, r1_fulfilled;
    logic [31:0] r1_address, r1_store_word, r1_loaded_word;
    logic [1:0]  r1_size;
    logic        m_valid, m_op, m_fulfilled;
    logic [31:0] m_address, m_store_word, m_loaded_word;
    logic [1:0]  m_size;

    int   n_tests;
    int   n_fail;
    txn_t q0[$];
    txn_t q1[$];
    int   obs_grants[$];

    memory_arbiter #(.XLEN(32), .MAX_LOCK(c_max_lock)) u_dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_op(r0_op), .r0_address(r0_address),
        .r0_size(r0_size), .r0_store_word(r0_store_word),
        .r0_fulfilled(r0_fulfilled), .r0_loaded_word(r0_loaded_word),
        .r1_valid(r1_valid), .r1_op(r1_op), .r1_address(r1_address),
        .r1_size(r1_size), .r1_store_word(r1_store_word),
        .r1_fulfilled(r1_fulfilled), .r1_loaded_word(r1_loaded_word),
        .m_valid(m_valid), .m_op(m_op), .m_address(m_address),
        .m_size(m_size), .m_store_word(m_store_word),
        .m_fulfilled(m_fulfilled), .m_loaded_word(m_loaded_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_all();
        reset = 1'b0;
        r0_valid = 1'b0; r0_op = 1'b0; r0_address = '0; r0_size = '0; r0_store_word = '0;
        r1_valid = 1'b0; r1_op = 1'b0; r1_address = '0; r1_size = '0; r1_store_word = '0;
        m_fulfilled = 1'b0; m_loaded_word = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_fulfil(output logic f0, output logic f1);
        @(negedge clk);
        m_fulfilled = 1'b1;
        m_loaded_word = $urandom;
        #1;
        f0 = r0_fulfilled;
        f1 = r1_fulfilled;
        @(negedge clk);
        m_fulfilled = 1'b0;
    endtask

    // Present the head of each requester queue (valid while non-empty).
    task automatic drive_heads();
        if (q0.size() > 0) begin
            r0_valid = 1'b1; r0_op = q0[0].op; r0_address = q0[0].addr;
            r0_size = q0[0].size; r0_store_word = q0[0].data;
        end else begin
            r0_valid = 1'b0; r0_op = 1'b0; r0_address = '0; r0_size = '0; r0_store_word = '0;
        end
        if (q1.size() > 0) begin
            r1_valid = 1'b1; r1_op = q1[0].op; r1_address = q1[0].addr;
            r1_size = q1[0].size; r1_store_word = q1[0].data;
        end else begin
            r1_valid = 1'b0; r1_op = 1'b0; r1_address = '0; r1_size = '0; r1_store_word = '0;
        end
    endtask

    task automatic fill_random(input int n0, input int n1);
        txn_t t;
        q0.delete();
        q1.delete();
        for (int i = 0; i < n0; i++) begin
            t.op = 1'b0; t.addr = $urandom; t.data = $urandom;
            t.size = 2'($urandom_range(2, 0));
            q0.push_back(t);
        end
        for (int i = 0; i < n1; i++) begin
            t.op = 1'($urandom_range(1, 0)); t.addr = $urandom; t.data = $urandom;
            t.size = 2'($urandom_range(2, 0));
            q1.push_back(t);
        end
    endtask

    // Serve the queued transactions with random memory latency and check
    // every completion against the grant order predicted from the rules.
    task automatic run_stream(input bit do_rst, input int start_last,
                              input int max_lat, input string name);
        int   exp_own[$];
        bit   exp_ret[$];
        int   c0, c1, last, run, total, idx, lat, wcnt, budget, own, pop_own;
        bit   prev_ret, done_pend, chk_after, ret_exp;
        txn_t h;
        logic [132:0] got, want;

        c0 = q0.size(); c1 = q1.size(); last = start_last; prev_ret = 1'b0; run = 0;
        while (c0 + c1 > 0) begin
            if (prev_ret)              own = last;
            else if (c0 > 0 && c1 > 0) own = 1 - last;
            else                       own = (c0 > 0) ? 0 : 1;
            if (own == 0) c0--; else c1--;
            run  = prev_ret ? run + 1 : 1;
            last = own;
`ifdef MEM_ARB_LOCK_EN
            prev_ret = ((((own == 0) ? c0 : c1) > 0) && (run < c_max_lock));
`else
            prev_ret = 1'b0;
`endif
            exp_own.push_back(own);
            exp_ret.push_back(prev_ret);
        end
        total = exp_own.size();
        obs_grants.delete();
        if (do_rst) do_reset();

        idx = 0; wcnt = 0; budget = 0; pop_own = 0;
        done_pend = 1'b0; chk_after = 1'b0; ret_exp = 1'b0;
        lat = $urandom_range(max_lat, 0);
        while ((idx < total || done_pend) && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (done_pend) begin
                if (pop_own == 0) void'(q0.pop_front());
                else              void'(q1.pop_front());
                m_fulfilled = 1'b0;
                done_pend = 1'b0;
            end
            drive_heads();
            #1;
            if (chk_after) begin
                n_tests++;
                if (m_valid !== ret_exp) begin
                    n_fail++;
                    $display("FAIL %s_after_done[%0d]: m_valid=%b expected %b", name, idx, m_valid, ret_exp);
                end
                chk_after = 1'b0;
            end
            if (m_valid === 1'b1 && idx < total) begin
                if (wcnt >= lat) begin
                    m_fulfilled = 1'b1;
                    m_loaded_word = $urandom;
                    #1;
                    own = exp_own[idx];
                    h = (own == 0) ? q0[0] : q1[0];
                    got  = {r0_fulfilled, r1_fulfilled, m_address, m_op, m_size,
                            m_store_word, r0_loaded_word, r1_loaded_word};
                    want = {(own == 0), (own == 1), h.addr, h.op, h.size,
                            h.data, m_loaded_word, m_loaded_word};
                    n_tests++;
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL %s_txn[%0d]: got %h expected %h (owner %0d)", name, idx, got, want, own);
                    end
                    obs_grants.push_back(({r1_fulfilled, r0_fulfilled} == 2'b01) ? 0 :
                                         ({r1_fulfilled, r0_fulfilled} == 2'b10) ? 1 : 2);
                    ret_exp = exp_ret[idx];
                    pop_own = own;
                    done_pend = 1'b1;
                    chk_after = 1'b1;
                    idx++;
                    wcnt = 0;
                    lat = $urandom_range(max_lat, 0);
                end else begin
                    wcnt++;
                end
            end else if (m_valid === 1'b0) begin
                n_tests++;
                if ({m_op, m_size, m_address, m_store_word} !== 67'd0) begin
                    n_fail++;
                    $display("FAIL %s_idle_zero: m_op/size/addr/data=%h expected 0", name,
                             {m_op, m_size, m_address, m_store_word});
                end
            end
        end
        if (idx < total || done_pend) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: completed %0d expected %0d", name, idx, total);
        end
        q0.delete();
        q1.delete();
        m_fulfilled = 1'b0;
        drive_heads();
    endtask

    task automatic test_reset();
        idle_all();
        do_reset();
        #1;
        n_tests++;
        if ({m_valid, r0_fulfilled, r1_fulfilled, m_op, m_size, m_address, m_store_word} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h expected 0",
                     {m_valid, r0_fulfilled, r1_fulfilled, m_op, m_size, m_address, m_store_word});
        end
    endtask

    task automatic test_idle_fulfill();
        logic [31:0] a0, a1;
        logic f0, f1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            m_fulfilled = 1'b1;
            m_loaded_word = $urandom;
            #1;
            n_tests++;
            if ({m_valid, r0_fulfilled, r1_fulfilled} !== 3'b000 || r0_loaded_word !== m_loaded_word) begin
                n_fail++;
                $display("FAIL idle_fulfill: valid/f0/f1=%b%b%b expected 000", m_valid, r0_fulfilled, r1_fulfilled);
            end
        end
        @(negedge clk);
        m_fulfilled = 1'b0;
        a0 = $urandom; a1 = $urandom;
        r0_valid = 1'b1; r0_address = a0;
        r1_valid = 1'b1; r1_address = a1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a0}) begin
            n_fail++;
            $display("FAIL idle_fulfill_tie: got %b/%h expected 1/%h", m_valid, m_address, a0);
        end
        pulse_fulfil(f0, f1);
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic [31:0] a0, a1;
        logic f0, f1;
        do_reset();
        a0 = $urandom; a1 = $urandom;
        r0_valid = 1'b1; r0_address = a0;
        r1_valid = 1'b1; r1_address = a1; r1_op = 1'b0;
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_latency: m_valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a0}) begin
            n_fail++;
            $display("FAIL tie_grant_r0: got %b/%h expected 1/%h", m_valid, m_address, a0);
        end
        pulse_fulfil(f0, f1);
        n_tests++;
        if ({f0, f1} !== 2'b10) begin
            n_fail++;
            $display("FAIL tie_r0_done: f0f1=%b%b expected 10", f0, f1);
        end
        r0_valid = 1'b0;
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_rearb: m_valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a1}) begin
            n_fail++;
            $display("FAIL tie_grant_r1: got %b/%h expected 1/%h", m_valid, m_address, a1);
        end
        pulse_fulfil(f0, f1);
        n_tests++;
        if ({f0, f1} !== 2'b01) begin
            n_fail++;
            $display("FAIL tie_r1_done: f0f1=%b%b expected 01", f0, f1);
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_store();
        int cnt0, cnt1;
        cnt0 = 0; cnt1 = 0;
        r1_valid = 1'b1; r1_op = 1'b1; r1_address = 32'h0000_1004;
        r1_store_word = 32'hDEAD_BEEF; r1_size = 2'd2;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 3) begin
                m_fulfilled = 1'b1;
                m_loaded_word = $urandom;
            end
            if (c == 4) idle_all();
            #1;
            cnt0 += int'(r0_fulfilled);
            cnt1 += int'(r1_fulfilled);
            if (c <= 3) begin
                n_tests++;
                if ({m_valid, m_op, m_address, m_size, m_store_word} !== {1'b1, 1'b1, 32'h0000_1004, 2'd2, 32'hDEAD_BEEF}) begin
                    n_fail++;
                    $display("FAIL store_fields[%0d]: got %b %b %h %0d %h", c, m_valid, m_op, m_address, m_size, m_store_word);
                end
            end
        end
        n_tests++;
        if (cnt1 !== 1 || cnt0 !== 0) begin
            n_fail++;
            $display("FAIL store_pulses: r1=%0d r0=%0d expected r1=1 r0=0", cnt1, cnt0);
        end
    endtask

    task automatic test_round_robin();
        int rr_exp[4];
`ifdef MEM_ARB_LOCK_EN
        rr_exp = '{0, 0, 1, 1};
`else
        rr_exp = '{0, 1, 0, 1};
`endif
        fill_random(2, 2);
        run_stream(1'b1, 1, 2, "rr");
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs_grants.size() <= i) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: missing grant expected %0d", i, rr_exp[i]);
            end else if (obs_grants[i] !== rr_exp[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, obs_grants[i], rr_exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] a0, a1;
        do_reset();
        a0 = $urandom; a1 = $urandom;
        r0_valid = 1'b1; r0_address = a0;
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a0}) begin
            n_fail++;
            $display("FAIL abort_grant: got %b/%h expected 1/%h", m_valid, m_address, a0);
        end
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        n_tests++;
        if ({m_valid, r0_fulfilled, r1_fulfilled} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_drop: valid/f0/f1=%b%b%b expected 000", m_valid, r0_fulfilled, r1_fulfilled);
        end
        @(negedge clk);
        r0_valid = 1'b1; r1_valid = 1'b1; r1_address = a1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a0}) begin
            n_fail++;
            $display("FAIL abort_keeps_last_owner: got %b/%h expected 1/%h", m_valid, m_address, a0);
        end
        @(negedge clk);
        r0_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: m_valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a1}) begin
            n_fail++;
            $display("FAIL abort_other_granted: got %b/%h expected 1/%h", m_valid, m_address, a1);
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] a0, a1;
        logic f0, f1;
        do_reset();
        a0 = $urandom; a1 = $urandom;
        r0_valid = 1'b1; r0_address = a0;
        @(negedge clk);
        pulse_fulfil(f0, f1);
        r1_valid = 1'b1; r1_address = a1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a1}) begin
            n_fail++;
            $display("FAIL rst_pre_grant: got %b/%h expected 1/%h", m_valid, m_address, a1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_fulfilled = 1'b1;
        #1;
        n_tests++;
        if ({m_valid, r0_fulfilled, r1_fulfilled} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid: valid/f0/f1=%b%b%b expected 000", m_valid, r0_fulfilled, r1_fulfilled);
        end
        @(negedge clk);
        m_fulfilled = 1'b0;
        reset = 1'b0;
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release_idle: m_valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_address} !== {1'b1, a0}) begin
            n_fail++;
            $display("FAIL rst_then_tie: got %b/%h expected 1/%h", m_valid, m_address, a0);
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            fill_random($urandom_range(10, 0), $urandom_range(10, 1));
            run_stream(1'b1, 1, 3, "rand");
        end
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock_burst(input int n_words);
        txn_t t;
        int lead;
        fill_random(1, 0);
        run_stream(1'b1, 1, 1, "lock_pre");
        fill_random(1, 0);
        for (int i = 0; i < n_words; i++) begin
            t.op = 1'b0; t.addr = 32'h200 + 32'(4 * i); t.data = $urandom; t.size = 2'd2;
            q1.push_back(t);
        end
        run_stream(1'b0, 0, 2, "lock_fill");
        lead = 0;
        while (lead < obs_grants.size() && obs_grants[lead] == 1) lead++;
        n_tests++;
        if (lead !== 8 || obs_grants.size() < 9 || obs_grants[8] !== 0) begin
            n_fail++;
            $display("FAIL lock_burst_%0d: r1 held %0d words expected 8 then r0", n_words, lead);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_all();
        test_reset();
        test_idle_fulfill();
        test_tie();
        test_store();
        test_round_robin();
        test_abort();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_LOCK_EN
        test_lock_burst(8);
        test_lock_burst(10);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
